// File: rtl/seq_shift_unit.sv
// ============================================================================
// Module      : seq_shift_unit
// Description : Multi-cycle shifter/rotator (SLL/SRL/SRA/ROR), STEP bits/clock,
//               start/busy/done handshake, registered result, carry and zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_shift_unit #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dout,
    output logic               carry_out,
    output logic               zero
);

    localparam logic [1:0]  c_SLL   = 2'b00;
    localparam logic [1:0]  c_SRL   = 2'b01;
    localparam logic [1:0]  c_SRA   = 2'b10;
    localparam logic [31:0] c_STEP  = 32'(STEP);
    localparam logic [31:0] c_WIDTH = 32'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_mode;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_dout;
    logic               r_carry;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_last;
    logic [31:0]        w_cnt_ext;
    logic [31:0]        w_n;
    logic [WIDTH-1:0]   w_sll;
    logic [WIDTH-1:0]   w_srl;
    logic [WIDTH-1:0]   w_sra;
    logic [WIDTH-1:0]   w_ror;
    logic [WIDTH-1:0]   w_sll_out;
    logic [WIDTH-1:0]   w_rt_out;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_carry;

    assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_cnt_ext = 32'(r_cnt);
    assign w_last    = (w_cnt_ext <= c_STEP);
    assign w_n       = w_last ? w_cnt_ext : c_STEP;

    // Shift by n in one go; the carry is the last bit to leave the word.
    assign w_sll     = r_dout << w_n;
    assign w_srl     = r_dout >> w_n;
    assign w_sra     = $signed(r_dout) >>> w_n;
    assign w_ror     = (r_dout >> w_n) | (r_dout << (c_WIDTH - w_n));
    assign w_sll_out = r_dout >> (c_WIDTH - w_n);
    assign w_rt_out  = r_dout >> (w_n - 32'd1);

    always_comb begin
        w_shifted = w_ror;
        w_carry   = w_rt_out[0];
        case (r_mode)
            c_SLL: begin
                w_shifted = w_sll;
                w_carry   = w_sll_out[0];
            end
            c_SRL:   w_shifted = w_srl;
            c_SRA:   w_shifted = w_sra;
            default: w_shifted = w_ror;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = (shamt == '0) ? S_DONE : S_SHIFT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= (w_state_next == S_SHIFT);
            r_done <= (w_state_next == S_DONE);
            if (w_accept) begin
                r_mode  <= mode;
                r_cnt   <= shamt;
                r_dout  <= din;
                r_carry <= 1'b0;
            end else if (r_state == S_SHIFT) begin
                r_dout  <= w_shifted;
                r_carry <= w_carry;
                r_cnt   <= r_cnt - w_n[SHAMT_W-1:0];
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign dout      = r_dout;
    assign carry_out = r_carry;
    assign zero      = (r_dout == '0);

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
// ============================================================================
// Module      : tb_seq_shift_unit
// Description : Directed, table-driven bench for seq_shift_unit (STEP=1 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_shift_unit;

    logic        clk;
    logic        rst1, rst4;
    logic        start1, start4;
    logic [1:0]  mode;
    logic [15:0] din;
    logic [4:0]  shamt;
    logic        busy1, done1, carry1, zero1;
    logic        busy4, done4, carry4, zero4;
    logic [15:0] dout1, dout4;

    int n_checks;
    int n_errors;

    seq_shift_unit #(.WIDTH(16), .SHAMT_W(5), .STEP(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .mode(mode), .din(din),
        .shamt(shamt), .busy(busy1), .done(done1), .dout(dout1),
        .carry_out(carry1), .zero(zero1)
    );

    seq_shift_unit #(.WIDTH(16), .SHAMT_W(5), .STEP(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .mode(mode), .din(din),
        .shamt(shamt), .busy(busy4), .done(done4), .dout(dout4),
        .carry_out(carry4), .zero(zero4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  m;
        logic [15:0] d;
        logic [4:0]  s;
        logic [15:0] ed;
        logic        ec;
        int          eb;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Caller is just after a negedge; returns at the negedge where done is seen.
    task automatic run_op(input string nm, input bit use4, input logic [1:0] m,
                          input logic [15:0] d, input logic [4:0] s,
                          input logic [15:0] ed, input logic ec, input int eb);
        int  nb;
        int  cyc;
        bit  seen;
        logic        b, dn, c, z;
        logic [15:0] q;
        nb   = 0;
        cyc  = 0;
        seen = 1'b0;
        mode = m; din = d; shamt = s;
        if (use4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0; start4 = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            b  = use4 ? busy4 : busy1;
            dn = use4 ? done4 : done1;
            if (dn) begin
                cyc  = i;
                seen = 1'b1;
                break;
            end
            if (b) nb++;
        end
        q = use4 ? dout4 : dout1;
        c = use4 ? carry4 : carry1;
        z = use4 ? zero4 : zero1;
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        chk({nm, "_latency"}, 32'(cyc), 32'(eb + 1));
        chk({nm, "_busy_cycles"}, 32'(nb), 32'(eb));
        chk({nm, "_dout"}, 32'(q), 32'(ed));
        chk({nm, "_carry"}, 32'(c), 32'(ec));
        chk({nm, "_zero"}, 32'(z), 32'(ed == 16'h0000));
    endtask

    initial begin
        int nb;
        int dn_cnt;
        n_checks = 0;
        n_errors = 0;

        tbl[0]  = '{"sll_8001_1",   2'd0, 16'h8001, 5'd1,  16'h0002, 1'b1, 1};
        tbl[1]  = '{"sra_8000_4",   2'd2, 16'h8000, 5'd4,  16'hF800, 1'b0, 4};
        tbl[2]  = '{"ror_0001_17",  2'd3, 16'h0001, 5'd17, 16'h8000, 1'b1, 17};
        tbl[3]  = '{"srl_ffff_20",  2'd1, 16'hFFFF, 5'd20, 16'h0000, 1'b0, 20};
        tbl[4]  = '{"sll_1234_0",   2'd0, 16'h1234, 5'd0,  16'h1234, 1'b0, 0};
        tbl[5]  = '{"sll_00f0_4",   2'd0, 16'h00F0, 5'd4,  16'h0F00, 1'b0, 4};
        tbl[6]  = '{"srl_00f0_5",   2'd1, 16'h00F0, 5'd5,  16'h0007, 1'b1, 5};
        tbl[7]  = '{"sra_7fff_15",  2'd2, 16'h7FFF, 5'd15, 16'h0000, 1'b1, 15};
        tbl[8]  = '{"sra_8001_31",  2'd2, 16'h8001, 5'd31, 16'hFFFF, 1'b1, 31};
        tbl[9]  = '{"ror_1234_4",   2'd3, 16'h1234, 5'd4,  16'h4123, 1'b0, 4};
        tbl[10] = '{"sll_ffff_16",  2'd0, 16'hFFFF, 5'd16, 16'h0000, 1'b1, 16};
        tbl[11] = '{"sll_0001_17",  2'd0, 16'h0001, 5'd17, 16'h0000, 1'b0, 17};
        tbl[12] = '{"ror_8000_15",  2'd3, 16'h8000, 5'd15, 16'h0001, 1'b0, 15};

        rst1 = 1'b1; rst4 = 1'b1;
        start1 = 1'b0; start4 = 1'b0;
        mode = 2'd0; din = 16'h0; shamt = 5'd0;
        #1;
        chk("reset_busy", 32'(busy1), 32'd0);
        chk("reset_done", 32'(done1), 32'd0);
        chk("reset_dout", 32'(dout1), 32'd0);
        chk("reset_carry", 32'(carry1), 32'd0);
        chk("reset_zero", 32'(zero1), 32'd1);
        repeat (2) @(negedge clk);
        rst1 = 1'b0; rst4 = 1'b0;
        @(negedge clk);

        // Entries run back-to-back: each start lands in the DONE cycle of the last.
        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].name, 1'b0, tbl[i].m, tbl[i].d, tbl[i].s,
                   tbl[i].ed, tbl[i].ec, tbl[i].eb);
        end
        @(negedge clk);
        chk("done_drops", 32'(done1), 32'd0);
        chk("dout_held", 32'(dout1), 32'h0001);

        // start during SHIFT must be ignored
        mode = 2'd2; din = 16'h8000; shamt = 5'd4; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        @(negedge clk);
        mode = 2'd0; din = 16'hFFFF; shamt = 5'd1; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        nb = 1;
        dn_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done1) begin
                dn_cnt = i + 2;
                break;
            end
            if (busy1) nb++;
        end
        chk("ign_latency", 32'(dn_cnt), 32'd5);
        chk("ign_busy", 32'(nb), 32'd4);
        chk("ign_dout", 32'(dout1), 32'hF800);
        chk("ign_carry", 32'(carry1), 32'd0);
        @(negedge clk);

        // STEP=4
        run_op("s4_sll_0001_6", 1'b1, 2'd0, 16'h0001, 5'd6, 16'h0040, 1'b0, 2);
        @(negedge clk);

        // STEP=4 aborted by reset in the first SHIFT cycle
        mode = 2'd0; din = 16'h0001; shamt = 5'd6; start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        @(negedge clk);
        chk("s4_abort_busy_before", 32'(busy4), 32'd1);
        #2 rst4 = 1'b1;
        #1;
        chk("s4_abort_busy", 32'(busy4), 32'd0);
        chk("s4_abort_dout", 32'(dout4), 32'd0);
        @(negedge clk);
        rst4 = 1'b0;
        dn_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done4) dn_cnt++;
        end
        chk("s4_abort_no_done", 32'(dn_cnt), 32'd0);
        chk("s4_abort_dout_after", 32'(dout4), 32'd0);

        // Asynchronous reset mid-clock during a STEP=1 operation
        mode = 2'd0; din = 16'h8001; shamt = 5'd10; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        @(posedge clk);
        #2 rst1 = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy1), 32'd0);
        chk("midrst_done", 32'(done1), 32'd0);
        chk("midrst_dout", 32'(dout1), 32'd0);
        chk("midrst_carry", 32'(carry1), 32'd0);
        chk("midrst_zero", 32'(zero1), 32'd1);
        @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
